// File: rtl/quotient_table_ctrl_if.sv
// ---------------------------------------------------------------------------
// quotient_table_ctrl_if
// Bundles every non-clock/reset signal of the quotient-table controller:
//   - load stream   : load_start, load_valid/load_ready, load_data
//   - status        : table_valid, busy
//   - lookup ports  : req{0,1}_valid/ready/addr, resp{0,1}_valid/data
//   - table RAM port: tbl_wen/waddr/wdata (write), tbl_raddr/tbl_rdata (read)
// master = surrounding system (loader, requesters, RAM); slave = controller.
// ---------------------------------------------------------------------------
interface quotient_table_ctrl_if #(
   parameter int unsigned RDATA_WIDTH_BITS = 3,
   parameter int unsigned RADDR_WIDTH      = 4,
   parameter int unsigned WDATA_WIDTH_BITS = 6,
   parameter int unsigned WADDR_WIDTH      = 1
);
   localparam int unsigned ENTRY_W = 1 << RDATA_WIDTH_BITS;
   localparam int unsigned WORD_W  = 1 << WDATA_WIDTH_BITS;

   // load stream and status
   logic                   load_start;
   logic                   load_valid;
   logic                   load_ready;
   logic [WORD_W-1:0]      load_data;
   logic                   table_valid;
   logic                   busy;

   // lookup requesters
   logic                   req0_valid;
   logic                   req0_ready;
   logic [RADDR_WIDTH-1:0] req0_addr;
   logic                   req1_valid;
   logic                   req1_ready;
   logic [RADDR_WIDTH-1:0] req1_addr;
   logic                   resp0_valid;
   logic [ENTRY_W-1:0]     resp0_data;
   logic                   resp1_valid;
   logic [ENTRY_W-1:0]     resp1_data;

   // table RAM
   logic                   tbl_wen;
   logic [WADDR_WIDTH-1:0] tbl_waddr;
   logic [WORD_W-1:0]      tbl_wdata;
   logic [RADDR_WIDTH-1:0] tbl_raddr;
   logic [ENTRY_W-1:0]     tbl_rdata;

   modport master (
      output load_start, load_valid, load_data,
      output req0_valid, req0_addr, req1_valid, req1_addr,
      output tbl_rdata,
      input  load_ready, table_valid, busy,
      input  req0_ready, req1_ready,
      input  resp0_valid, resp0_data, resp1_valid, resp1_data,
      input  tbl_wen, tbl_waddr, tbl_wdata, tbl_raddr
   );

   modport slave (
      input  load_start, load_valid, load_data,
      input  req0_valid, req0_addr, req1_valid, req1_addr,
      input  tbl_rdata,
      output load_ready, table_valid, busy,
      output req0_ready, req1_ready,
      output resp0_valid, resp0_data, resp1_valid, resp1_data,
      output tbl_wen, tbl_waddr, tbl_wdata, tbl_raddr
   );
endinterface

// File: rtl/quotient_table_ctrl.sv
// ---------------------------------------------------------------------------
// quotient_table_ctrl
// Fills the divider's quotient-selection table RAM from a valid/ready word
// stream after each load_start, then arbitrates lookups from two requesters
// onto the single asynchronous read port (round-robin). Each granted lookup
// returns a registered response one cycle after its handshake.
// Ports:
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - quotient_table_ctrl_if.slave (load stream, status, lookup
//             requesters/responses, table RAM read/write port)
// ---------------------------------------------------------------------------
module quotient_table_ctrl #(
   parameter int unsigned RDATA_WIDTH_BITS = 3,
   parameter int unsigned RADDR_WIDTH      = 4,
   parameter int unsigned WDATA_WIDTH_BITS = 6,
   parameter int unsigned WADDR_WIDTH      = 1
) (
   input logic                  clock,
   input logic                  reset_n,
   quotient_table_ctrl_if.slave bus
);
   localparam int unsigned ENTRY_W   = 1 << RDATA_WIDTH_BITS;
   localparam int unsigned WORD_W    = 1 << WDATA_WIDTH_BITS;
   localparam int unsigned NUM_WORDS = 1 << WADDR_WIDTH;
   localparam logic [WADDR_WIDTH-1:0] LAST_WORD = WADDR_WIDTH'(NUM_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2
   } state_t;

   state_t                 r_state;
   logic [WADDR_WIDTH-1:0] r_cnt;
   logic                   r_rr_ptr;
   logic                   r_resp0_valid;
   logic [ENTRY_W-1:0]     r_resp0_data;
   logic                   r_resp1_valid;
   logic [ENTRY_W-1:0]     r_resp1_data;

   state_t                 w_state_nxt;
   logic [WADDR_WIDTH-1:0] w_cnt_nxt;
   logic                   w_rr_nxt;
   logic                   w_load_ready;
   logic                   w_load_hs;
   logic                   w_gnt0;
   logic                   w_gnt1;

   // State, word counter and round-robin pointer registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_rr_ptr <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_rr_ptr <= w_rr_nxt;
      end
   end

   // Next-state, load handshake and lookup arbitration
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_rr_nxt     = r_rr_ptr;
      w_load_ready = 1'b0;
      w_load_hs    = 1'b0;
      w_gnt0       = 1'b0;
      w_gnt1       = 1'b0;

      case (r_state)
         ST_IDLE: begin
         end
         ST_LOAD: begin
            w_load_ready = 1'b1;
            if (bus.load_valid) begin
               w_load_hs = 1'b1;
               w_cnt_nxt = r_cnt + WADDR_WIDTH'(1);
               if (r_cnt == LAST_WORD) begin
                  w_state_nxt = ST_READY;
               end
            end
         end
         ST_READY: begin
            // Pointer names the favoured side only when both requesters collide
            if (bus.req0_valid && bus.req1_valid) begin
               w_gnt0 = ~r_rr_ptr;
               w_gnt1 = r_rr_ptr;
            end else begin
               w_gnt0 = bus.req0_valid;
               w_gnt1 = bus.req1_valid;
            end
            if (w_gnt0) begin
               w_rr_nxt = 1'b1;
            end else if (w_gnt1) begin
               w_rr_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // load_start overrides everything: restart the fill, block the word and any grant
      if (bus.load_start) begin
         w_state_nxt  = ST_LOAD;
         w_cnt_nxt    = '0;
         w_rr_nxt     = r_rr_ptr;
         w_load_ready = 1'b0;
         w_load_hs    = 1'b0;
         w_gnt0       = 1'b0;
         w_gnt1       = 1'b0;
      end
   end

   // Lookup responses: capture the asynchronous read data at the grant edge
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_resp0_valid <= 1'b0;
         r_resp0_data  <= '0;
         r_resp1_valid <= 1'b0;
         r_resp1_data  <= '0;
      end else begin
         r_resp0_valid <= w_gnt0;
         r_resp1_valid <= w_gnt1;
         if (w_gnt0) begin
            r_resp0_data <= bus.tbl_rdata;
         end
         if (w_gnt1) begin
            r_resp1_data <= bus.tbl_rdata;
         end
      end
   end

   // Status
   assign bus.load_ready  = w_load_ready;
   assign bus.busy        = (r_state == ST_LOAD);
   assign bus.table_valid = (r_state == ST_READY);

   // Grants
   assign bus.req0_ready = w_gnt0;
   assign bus.req1_ready = w_gnt1;

   // Responses
   assign bus.resp0_valid = r_resp0_valid;
   assign bus.resp0_data  = r_resp0_data;
   assign bus.resp1_valid = r_resp1_valid;
   assign bus.resp1_data  = r_resp1_data;

   // Table write port is quiet (all zero) except on an accepted load word
   assign bus.tbl_wen   = w_load_hs;
   assign bus.tbl_waddr = w_load_hs ? r_cnt : '0;
   assign bus.tbl_wdata = w_load_hs ? bus.load_data : WORD_W'(0);

   // Read address follows the granted requester; parked at 0 outside READY
   assign bus.tbl_raddr = (r_state != ST_READY) ? '0 :
                          (w_gnt1 ? bus.req1_addr : bus.req0_addr);

endmodule

// File: tb/tb_quotient_table_ctrl.sv
// ---------------------------------------------------------------------------
// tb_quotient_table_ctrl
// Directed scenarios followed by randomized traffic; a transaction-level
// model of the controller is checked against the DUT on every falling edge.
// ---------------------------------------------------------------------------
module tb_quotient_table_ctrl;
   localparam int unsigned RDW  = 3;
   localparam int unsigned RAW  = 4;
   localparam int unsigned WDW  = 6;
   localparam int unsigned WAW  = 1;
   localparam int          NENT = 16;
   localparam int          NWRD = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   quotient_table_ctrl_if #(.RDATA_WIDTH_BITS(RDW), .RADDR_WIDTH(RAW),
                            .WDATA_WIDTH_BITS(WDW), .WADDR_WIDTH(WAW)) bus ();

   quotient_table_ctrl #(.RDATA_WIDTH_BITS(RDW), .RADDR_WIDTH(RAW),
                         .WDATA_WIDTH_BITS(WDW), .WADDR_WIDTH(WAW)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   // Table RAM: asynchronous read, 8-entry word write
   logic [7:0] ram [NENT];
   assign bus.tbl_rdata = ram[bus.tbl_raddr];
   always @(posedge clk) begin
      if (bus.tbl_wen) begin
         for (int k = 0; k < 8; k++) ram[{bus.tbl_waddr, 3'(k)}] <= bus.tbl_wdata[8*k +: 8];
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef enum int {M_IDLE, M_LOAD, M_READY} mmode_t;
   mmode_t     m_mode = M_IDLE;
   int         m_words = 0;
   int         m_ptr = 0;
   logic [7:0] m_tbl [NENT];
   bit         m_r0v = 0, m_r1v = 0;
   logic [7:0] m_r0d = 8'h00, m_r1d = 8'h00;

   always @(negedge clk) begin : model
      int g;
      bit lr;
      bit hs;
      if (!rst_n) begin
         chk("rst_load_ready", 64'(bus.load_ready), 64'd0);
         chk("rst_table_valid", 64'(bus.table_valid), 64'd0);
         chk("rst_busy", 64'(bus.busy), 64'd0);
         chk("rst_req0_ready", 64'(bus.req0_ready), 64'd0);
         chk("rst_req1_ready", 64'(bus.req1_ready), 64'd0);
         chk("rst_resp0_valid", 64'(bus.resp0_valid), 64'd0);
         chk("rst_resp1_valid", 64'(bus.resp1_valid), 64'd0);
         chk("rst_resp0_data", 64'(bus.resp0_data), 64'd0);
         chk("rst_resp1_data", 64'(bus.resp1_data), 64'd0);
         chk("rst_tbl_wen", 64'(bus.tbl_wen), 64'd0);
         chk("rst_tbl_waddr", 64'(bus.tbl_waddr), 64'd0);
         chk("rst_tbl_wdata", bus.tbl_wdata, 64'd0);
         chk("rst_tbl_raddr", 64'(bus.tbl_raddr), 64'd0);
         m_mode = M_IDLE; m_words = 0; m_ptr = 0;
         m_r0v = 0; m_r1v = 0; m_r0d = 8'h00; m_r1d = 8'h00;
      end else begin
         lr = (m_mode == M_LOAD) && !bus.load_start;
         hs = lr && bus.load_valid;
         g  = -1;
         if (m_mode == M_READY && !bus.load_start) begin
            if (bus.req0_valid && bus.req1_valid) g = m_ptr;
            else if (bus.req0_valid)              g = 0;
            else if (bus.req1_valid)              g = 1;
         end
         chk("load_ready", 64'(bus.load_ready), 64'(lr));
         chk("busy", 64'(bus.busy), 64'(m_mode == M_LOAD));
         chk("table_valid", 64'(bus.table_valid), 64'(m_mode == M_READY));
         chk("req0_ready", 64'(bus.req0_ready), 64'(g == 0));
         chk("req1_ready", 64'(bus.req1_ready), 64'(g == 1));
         chk("tbl_wen", 64'(bus.tbl_wen), 64'(hs));
         if (hs) begin
            chk("tbl_waddr", 64'(bus.tbl_waddr), 64'(m_words));
            chk("tbl_wdata", bus.tbl_wdata, bus.load_data);
         end
         if (m_mode == M_READY)
            chk("tbl_raddr", 64'(bus.tbl_raddr), 64'((g == 1) ? bus.req1_addr : bus.req0_addr));
         chk("resp0_valid", 64'(bus.resp0_valid), 64'(m_r0v));
         chk("resp0_data", 64'(bus.resp0_data), 64'(m_r0d));
         chk("resp1_valid", 64'(bus.resp1_valid), 64'(m_r1v));
         chk("resp1_data", 64'(bus.resp1_data), 64'(m_r1d));

         // advance to the state after the coming rising edge
         m_r0v = (g == 0);
         m_r1v = (g == 1);
         if (g == 0) m_r0d = m_tbl[bus.req0_addr];
         if (g == 1) m_r1d = m_tbl[bus.req1_addr];
         if (g >= 0) m_ptr = (g == 0) ? 1 : 0;
         if (bus.load_start) begin
            m_mode = M_LOAD; m_words = 0;
         end else if (hs) begin
            for (int k = 0; k < 8; k++) m_tbl[m_words*8 + k] = bus.load_data[8*k +: 8];
            if (m_words == NWRD - 1) m_mode = M_READY;
            m_words++;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   bit h0, h1;

   initial begin
      rst_n = 1'b0;
      bus.load_start = 0; bus.load_valid = 0; bus.load_data = '0;
      bus.req0_valid = 0; bus.req0_addr = '0; bus.req1_valid = 0; bus.req1_addr = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // no grant while the table is invalid
      bus.req0_valid = 1; bus.req0_addr = 4'h2;
      repeat (4) begin
         smp(); chk("lit_no_grant_invalid", 64'(bus.req0_ready), 64'd0);
         cyc();
      end
      bus.req0_valid = 0;

      // full load
      bus.load_start = 1;
      cyc(); bus.load_start = 0; bus.load_valid = 1; bus.load_data = 64'h0706050403020100;
      smp(); chk("lit_w0_wen", 64'(bus.tbl_wen), 64'd1); chk("lit_w0_waddr", 64'(bus.tbl_waddr), 64'd0);
      cyc(); bus.load_data = 64'h0F0E0D0C0B0A0908;
      smp(); chk("lit_w1_wen", 64'(bus.tbl_wen), 64'd1); chk("lit_w1_waddr", 64'(bus.tbl_waddr), 64'd1);
      cyc(); bus.load_valid = 0; bus.req0_valid = 1; bus.req0_addr = 4'hA;
      smp(); chk("lit_table_valid", 64'(bus.table_valid), 64'd1); chk("lit_first_grant", 64'(bus.req0_ready), 64'd1);
      cyc(); bus.req0_valid = 0;
      smp(); chk("lit_resp0_valid", 64'(bus.resp0_valid), 64'd1); chk("lit_resp0_data", 64'(bus.resp0_data), 64'h0A);

      // lone req1 returns the pointer to requester 0
      bus.req1_valid = 1; bus.req1_addr = 4'h5;
      smp(); chk("lit_req1_alone", 64'(bus.req1_ready), 64'd1);
      cyc(); bus.req1_valid = 0;

      // contention: grants alternate 0,1,0,1
      bus.req0_valid = 1; bus.req0_addr = 4'd3; bus.req1_valid = 1; bus.req1_addr = 4'd12;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) cyc();
         smp();
         chk("lit_cont_gnt0", 64'(bus.req0_ready), 64'((i % 2) == 0));
         chk("lit_cont_gnt1", 64'(bus.req1_ready), 64'((i % 2) == 1));
         if (i == 0) chk("lit_resp1_alone", 64'(bus.resp1_data), 64'h05);
         else if ((i % 2) == 1) chk("lit_cont_resp0", 64'(bus.resp0_data), 64'h03);
         else chk("lit_cont_resp1", 64'(bus.resp1_data), 64'h0C);
      end
      cyc(); bus.req0_valid = 0; bus.req1_valid = 0;
      smp(); chk("lit_cont_last", 64'({bus.resp1_valid, bus.resp1_data}), 64'h10C);

      // restart mid-load
      cyc(); bus.load_start = 1;
      cyc(); bus.load_start = 0; bus.load_valid = 1; bus.load_data = 64'hDEADBEEFCAFEF00D;
      smp(); chk("lit_rs_w0", 64'(bus.tbl_wen), 64'd1);
      cyc(); bus.load_start = 1; bus.load_data = 64'h1111111111111111;
      smp(); chk("lit_rs_blocked_ready", 64'(bus.load_ready), 64'd0); chk("lit_rs_blocked_wen", 64'(bus.tbl_wen), 64'd0);
      cyc(); bus.load_start = 0; bus.load_data = 64'h8786858483828180;
      smp(); chk("lit_rs_waddr0", 64'(bus.tbl_waddr), 64'd0);
      cyc(); bus.load_data = 64'h8F8E8D8C8B8A8988;
      smp(); chk("lit_rs_waddr1", 64'(bus.tbl_waddr), 64'd1);

      // reload from READY while req1 is pending, with a stalled stream
      cyc(); bus.load_valid = 0; bus.req1_valid = 1; bus.req1_addr = 4'd7;
      smp(); chk("lit_rl_grant", 64'(bus.req1_ready), 64'd1);
      cyc(); bus.load_start = 1;
      smp(); chk("lit_rl_blocked", 64'(bus.req1_ready), 64'd0);
      chk("lit_rl_resp", 64'({bus.resp1_valid, bus.resp1_data}), 64'h187);
      cyc(); bus.load_start = 0; bus.load_valid = 1; bus.load_data = 64'h4746454443424140;
      smp(); chk("lit_st_wen0", 64'(bus.tbl_wen), 64'd1); chk("lit_st_hold", 64'(bus.req1_ready), 64'd0);
      cyc(); bus.load_valid = 0;
      smp(); chk("lit_st_gap", 64'(bus.tbl_wen), 64'd0); chk("lit_st_tv0", 64'(bus.table_valid), 64'd0);
      cyc(); bus.load_valid = 1; bus.load_data = 64'h4F4E4D4C4B4A4948;
      smp(); chk("lit_st_wen1", 64'(bus.tbl_wen), 64'd1); chk("lit_st_waddr1", 64'(bus.tbl_waddr), 64'd1);
      cyc(); bus.load_valid = 0;
      smp(); chk("lit_st_tv1", 64'(bus.table_valid), 64'd1); chk("lit_st_regrant", 64'(bus.req1_ready), 64'd1);
      cyc(); bus.req1_valid = 0;
      smp(); chk("lit_st_newdata", 64'({bus.resp1_valid, bus.resp1_data}), 64'h147);

      // randomized traffic, with an asynchronous reset in the middle
      h0 = 0; h1 = 0;
      for (int i = 0; i < 3000; i++) begin
         cyc();
         if (i == 1500) rst_n = 1'b0;
         if (i == 1504) rst_n = 1'b1;
         bus.load_start = ($urandom_range(0, 63) == 0);
         bus.load_valid = 1'($urandom_range(0, 1));
         bus.load_data  = {$urandom, $urandom};
         if (!bus.req0_valid || h0) begin
            bus.req0_valid = 1'($urandom_range(0, 1));
            bus.req0_addr  = 4'($urandom_range(0, 15));
         end
         if (!bus.req1_valid || h1) begin
            bus.req1_valid = 1'($urandom_range(0, 1));
            bus.req1_addr  = 4'($urandom_range(0, 15));
         end
         smp();
         h0 = bus.req0_valid & bus.req0_ready;
         h1 = bus.req1_valid & bus.req1_ready;
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/quotient_table_ctrl.md
# quotient_table_ctrl

Controller for the divider's quotient-selection table RAM, a 2^RADDR_WIDTH-entry table with 2^RDATA_WIDTH_BITS-bit entries, an asynchronous read port and a wide write port. It fills the table from a valid/ready word stream after each `load_start`. It then arbitrates lookups from two divider requesters onto the single read port, round-robin. Each granted lookup returns a registered response one cycle after its handshake.

## Interface
- RDATA_WIDTH_BITS, 3, log2 of entry width (entry = 8 bits)
- RADDR_WIDTH, 4, table address width (16 entries)
- WDATA_WIDTH_BITS, 6, log2 of write word width (64 bits, 8 entries/word)
- WADDR_WIDTH, 1, write word address width (2 words per full load)

- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_start  in  1  begin (re)load of the whole table; single-cycle pulse
- load_valid  in  1  load_data valid
- load_ready  out  1  controller accepts load_data this cycle
- load_data  in  2^WDATA_WIDTH_BITS  table word; byte k → entry {word_index, k}
- table_valid  out  1  table fully loaded, lookups enabled
- busy  out  1  state == LOAD
- req0_valid / req1_valid  in  1  lookup request
- req0_ready / req1_ready  out  1  grant; handshake = valid & ready
- req0_addr / req1_addr  in  RADDR_WIDTH  entry index
- resp0_valid / resp1_valid  out  1  one-cycle response pulse
- resp0_data / resp1_data  out  2^RDATA_WIDTH_BITS  looked-up entry
- tbl_wen  out  1  table write enable
- tbl_waddr  out  WADDR_WIDTH  table word address
- tbl_wdata  out  2^WDATA_WIDTH_BITS  table write word
- tbl_raddr  out  RADDR_WIDTH  table read address
- tbl_rdata  in  2^RDATA_WIDTH_BITS  table read data (combinational from tbl_raddr)

## Operation
- States: IDLE (reset, table invalid), LOAD, READY.
- Reset values:
  - state IDLE; table_valid 0; busy 0; load_ready 0.
  - req*_ready 0; resp*_valid 0; resp*_data 0.
  - tbl_wen 0; tbl_waddr 0; tbl_wdata 0; tbl_raddr 0.
  - word counter 0; round-robin pointer 0 (requester 0 favoured).
- Entering LOAD:
  - `load_start` in any state → LOAD; counter cleared; table_valid drops to 0 on the next edge.
  - `load_start` during LOAD restarts at word 0.
- Load handshake:
  - load_ready = (state == LOAD) & ~load_start.
  - On handshake: tbl_wen = 1, tbl_waddr = counter, tbl_wdata = load_data, all combinational in the same cycle; the counter increments.
  - Handshake with counter == 2^WADDR_WIDTH-1 → READY, table_valid = 1.
- Outside READY (or with load_start high), all req*_ready = 0. Requesters hold valid/addr; nothing is dropped.
- Arbitration in READY:
  - Only one requester valid → grant it; pointer := other requester.
  - Both valid → grant the pointer side; pointer flips.
  - None valid → pointer unchanged.
- Read path: tbl_raddr = granted requester's addr (req0_addr when no grant). tbl_rdata is captured into the granted requester's resp_data at the edge; resp_valid pulses the following cycle.
- resp*_data holds its last value when resp*_valid is low. Responses have no backpressure.
- A response for a grant made in the cycle before `load_start` is still delivered.
- Writes and reads never overlap, because grants occur only in READY.

## Timing
- Load: one word per cycle when load_valid is held. The last word handshake is at cycle N; table_valid = 1 from cycle N+1. First grant is possible at N+1.
- Lookup latency: handshake at cycle T → resp_valid = 1 at T+1 only.
- Lookup throughput: one lookup per cycle total. Under continuous contention each requester is granted every other cycle.
- reset_n low at any time (including mid-load) → all state and outputs return to reset values immediately. After reset the table must be reloaded before table_valid is set.

## Test plan
- Reset: assert reset_n = 0 mid-run → all outputs 0, state IDLE. With table_valid = 0, req0_valid = 1 → req0_ready stays 0 indefinitely.
- Full load + lookup:
  - Pulse load_start, then stream 0x0706050403020100 and 0x0F0E0D0C0B0A0908 back-to-back → tbl_wen on 2 consecutive cycles with waddr 0, 1; table_valid next cycle.
  - Then req0_addr = 0xA → resp0_valid 1 cycle later with resp0_data = 0x0A.
- Contention: both requesters valid for 4 cycles, addrs 3 and 12 → grants alternate 0,1,0,1; resp0_data = 0x03 and resp1_data = 0x0C on alternating cycles.
- Restart: load_start during LOAD after word 0 accepted, with load_valid high in the same cycle → that word not accepted, counter back to 0. The next two words land at waddr 0, 1.
- Reload from READY: load_start while req1_valid is high → req1_ready 0 that cycle and through LOAD. A response granted the previous cycle is still delivered. After reload, req1 is served with the new table contents.
- Stall: load_valid toggles 1,0,1 → tbl_wen only on valid cycles; table_valid rises one cycle after the second accepted word.
